// File: rtl/tmds_deserializer.sv
// Rebuilds 10-bit TMDS symbols from 2-bit DDR pairs and word-aligns them by hunting control tokens on channel 0.
// One symbol every 5 clocks, first strobe 6 clocks after reset release; no backpressure, the consumer must keep up.
module tmds_deserializer #(
  parameter int NUM_CHANNELS  = 3,
  parameter int LOCK_COUNT    = 4,
  parameter int SEARCH_WINDOW = 2048,
  parameter int UNLOCK_WINDOW = 4096
) (
  input  logic                         clk_pixel_x5,
  input  logic                         reset,
  input  logic [NUM_CHANNELS-1:0][1:0] tmds_pair,
  output logic [NUM_CHANNELS-1:0][9:0] tmds_internal,
  output logic                         word_valid,
  output logic                         locked,
  output logic [3:0]                   bit_offset,
  output logic                         token_valid,
  output logic [1:0]                   ctrl
);

  localparam int RUN_W  = $clog2(LOCK_COUNT + 1);
  localparam int WIN_W  = $clog2(SEARCH_WINDOW + 1);
  localparam int IDLE_W = $clog2(UNLOCK_WINDOW + 1);
  localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(LOCK_COUNT);
  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(SEARCH_WINDOW - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(UNLOCK_WINDOW - 1);

  typedef enum logic [1:0] {S_SEARCH, S_CONFIRM, S_LOCKED} state_t;

  state_t                        r_state, w_state_nxt;
  logic [NUM_CHANNELS-1:0][19:0] r_hist;
  logic [2:0]                    r_phase;
  logic                          r_cap;
  logic [NUM_CHANNELS-1:0][9:0]  r_data;
  logic                          r_word_vld;
  logic                          r_tok_vld;
  logic                          r_locked, w_locked_nxt;
  logic [1:0]                    r_ctrl;
  logic [3:0]                    r_offset, w_offset_nxt, w_offset_inc;
  logic [RUN_W-1:0]              r_run, w_run_nxt, w_run_inc;
  logic [WIN_W-1:0]              r_win, w_win_nxt;
  logic [IDLE_W-1:0]             r_idle, w_idle_nxt;
  logic [NUM_CHANNELS-1:0][9:0]  w_cand;
  logic                          w_is_token;
  logic [1:0]                    w_tok_ctrl;

  // r_cap is high the cycle after phase 4, when r_hist holds the freshly completed window.
  always_comb begin
    w_cand = '0;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      w_cand[ch] = r_hist[ch][{1'b0, r_offset} +: 10];
    end
  end

  always_comb begin
    w_is_token = 1'b1;
    w_tok_ctrl = 2'b00;
    case (w_cand[0])
      10'b1101010100: w_tok_ctrl = 2'b00;
      10'b0010101011: w_tok_ctrl = 2'b01;
      10'b0101010100: w_tok_ctrl = 2'b10;
      10'b1010101011: w_tok_ctrl = 2'b11;
      default:        w_is_token = 1'b0;
    endcase
  end

  assign w_offset_inc = (r_offset >= 4'd9) ? 4'd0 : r_offset + 4'd1;
  assign w_run_inc    = (r_run == RUN_LAST) ? r_run : r_run + 1'b1;

  // Windows count completed non-token symbols; the symbol arriving with the count at its
  // last value is the one that slips/unlocks, and a token on that symbol pre-empts it.
  always_comb begin
    w_state_nxt  = r_state;
    w_locked_nxt = r_locked;
    w_offset_nxt = r_offset;
    w_run_nxt    = r_run;
    w_win_nxt    = r_win;
    w_idle_nxt   = r_idle;
    if (r_cap) begin
      case (r_state)
        S_SEARCH: begin
          if (w_is_token) begin
            w_run_nxt = RUN_W'(1);
            w_win_nxt = '0;
            if (LOCK_COUNT <= 1) begin
              w_state_nxt  = S_LOCKED;
              w_locked_nxt = 1'b1;
              w_idle_nxt   = '0;
            end else begin
              w_state_nxt = S_CONFIRM;
            end
          end else if (r_win >= WIN_LAST) begin
            w_win_nxt    = '0;
            w_offset_nxt = w_offset_inc;
          end else begin
            w_win_nxt = r_win + 1'b1;
          end
        end
        S_CONFIRM: begin
          if (w_is_token) begin
            w_run_nxt = w_run_inc;
            if (w_run_inc >= RUN_LAST) begin
              w_state_nxt  = S_LOCKED;
              w_locked_nxt = 1'b1;
              w_idle_nxt   = '0;
            end
          end else begin
            w_state_nxt = S_SEARCH;
            w_run_nxt   = '0;
            w_win_nxt   = '0;
          end
        end
        S_LOCKED: begin
          if (w_is_token) begin
            w_idle_nxt = '0;
          end else if (r_idle >= IDLE_LAST) begin
            w_state_nxt  = S_SEARCH;
            w_locked_nxt = 1'b0;
            w_offset_nxt = w_offset_inc;
            w_idle_nxt   = '0;
            w_win_nxt    = '0;
            w_run_nxt    = '0;
          end else begin
            w_idle_nxt = r_idle + 1'b1;
          end
        end
        default: w_state_nxt = S_SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk_pixel_x5) begin
    if (!reset) begin
      r_hist     <= '0;
      r_phase    <= '0;
      r_cap      <= 1'b0;
      r_data     <= '0;
      r_word_vld <= 1'b0;
      r_tok_vld  <= 1'b0;
      r_ctrl     <= 2'b00;
      r_state    <= S_SEARCH;
      r_locked   <= 1'b0;
      r_offset   <= '0;
      r_run      <= '0;
      r_win      <= '0;
      r_idle     <= '0;
    end else begin
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        r_hist[ch] <= {tmds_pair[ch], r_hist[ch][19:2]};
      end
      r_phase    <= (r_phase == 3'd4) ? 3'd0 : r_phase + 3'd1;
      r_cap      <= (r_phase == 3'd4);
      r_word_vld <= r_cap;
      r_tok_vld  <= r_cap & w_is_token;
      if (r_cap) begin
        r_data <= w_cand;
        if (w_is_token) begin
          r_ctrl <= w_tok_ctrl;
        end
      end
      r_state  <= w_state_nxt;
      r_locked <= w_locked_nxt;
      r_offset <= w_offset_nxt;
      r_run    <= w_run_nxt;
      r_win    <= w_win_nxt;
      r_idle   <= w_idle_nxt;
    end
  end

  assign tmds_internal = r_data;
  assign word_valid    = r_word_vld;
  assign locked        = r_locked;
  assign bit_offset    = r_offset;
  assign token_valid   = r_tok_vld;
  assign ctrl          = r_ctrl;

endmodule

// File: tb/tb_tmds_deserializer.sv
// Directed bench for tmds_deserializer: serializes symbols bit 0 first with a chosen bit delay
// and checks alignment, lock, token decode and reset behaviour against hand-derived strobe indices.
module tb_tmds_deserializer;

  localparam int NCH = 3;
  localparam logic [9:0] T00 = 10'b1101010100;
  localparam logic [9:0] T01 = 10'b0010101011;
  localparam logic [9:0] T11 = 10'b1010101011;
  localparam logic [9:0] DAT = 10'h1F3;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NCH-1:0][1:0] pair;
  logic [NCH-1:0][9:0] tmds_internal;
  logic                word_valid;
  logic                locked;
  logic [3:0]          bit_offset;
  logic                token_valid;
  logic [1:0]          ctrl;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc, n_strobe, first_cyc, second_cyc, sym_idx;

  logic [NCH-1:0][9:0] snap_data;
  logic                snap_locked;
  logic                snap_tok;
  logic [3:0]          snap_off;
  logic [1:0]          snap_ctrl;

  bit         bq0[$], bq1[$], bq2[$];
  logic [9:0] sent0[$], sent1[$], sent2[$];

  always #5 clk = ~clk;

  tmds_deserializer #(
    .NUM_CHANNELS (NCH),
    .LOCK_COUNT   (4),
    .SEARCH_WINDOW(16),
    .UNLOCK_WINDOW(32)
  ) dut (
    .clk_pixel_x5 (clk),
    .reset        (rst_n),
    .tmds_pair    (pair),
    .tmds_internal(tmds_internal),
    .word_valid   (word_valid),
    .locked       (locked),
    .bit_offset   (bit_offset),
    .token_valid  (token_valid),
    .ctrl         (ctrl)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Strobe j shows the symbol sent two calls earlier.
  task automatic chk_words(input string tag);
    chk({tag, "_ch0"}, 32'(snap_data[0]), 32'(sent0[sym_idx-3]));
    chk({tag, "_ch1"}, 32'(snap_data[1]), 32'(sent1[sym_idx-3]));
    chk({tag, "_ch2"}, 32'(snap_data[2]), 32'(sent2[sym_idx-3]));
  endtask

  task automatic tick();
    pair[0][0] = (bq0.size() > 0) ? bq0.pop_front() : 1'b0;
    pair[0][1] = (bq0.size() > 0) ? bq0.pop_front() : 1'b0;
    pair[1][0] = (bq1.size() > 0) ? bq1.pop_front() : 1'b0;
    pair[1][1] = (bq1.size() > 0) ? bq1.pop_front() : 1'b0;
    pair[2][0] = (bq2.size() > 0) ? bq2.pop_front() : 1'b0;
    pair[2][1] = (bq2.size() > 0) ? bq2.pop_front() : 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    if (word_valid) begin
      n_strobe++;
      if (n_strobe == 1) first_cyc = cyc;
      if (n_strobe == 2) second_cyc = cyc;
      snap_data   = tmds_internal;
      snap_locked = locked;
      snap_off    = bit_offset;
      snap_tok    = token_valid;
      snap_ctrl   = ctrl;
    end
  endtask

  task automatic send_sym(input logic [9:0] s0, input logic [9:0] s1, input logic [9:0] s2);
    for (int i = 0; i < 10; i++) begin
      bq0.push_back(s0[i]);
      bq1.push_back(s1[i]);
      bq2.push_back(s2[i]);
    end
    sent0.push_back(s0);
    sent1.push_back(s1);
    sent2.push_back(s2);
    repeat (5) tick();
    sym_idx++;
  endtask

  task automatic reset_assert(input int n);
    rst_n = 1'b0;
    pair  = '0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic release_rst(input int delay);
    bq0.delete(); bq1.delete(); bq2.delete();
    sent0.delete(); sent1.delete(); sent2.delete();
    for (int i = 0; i < delay; i++) begin
      bq0.push_back(1'b0);
      bq1.push_back(1'b0);
      bq2.push_back(1'b0);
    end
    cyc = 0; n_strobe = 0; sym_idx = 0; first_cyc = 0; second_cyc = 0;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [9:0] t3_seq [10];
    logic [9:0] d_seq  [6];
    t3_seq = '{T00, T00, T01, DAT, T00, T00, T00, T00, T00, T00};
    d_seq  = '{10'h1F3, 10'h2C5, 10'h0F0, 10'h31C, 10'h055, 10'h3C3};

    // Reset state
    reset_assert(3);
    chk("rst_word_valid", 32'(word_valid), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_offset", 32'(bit_offset), 0);
    chk("rst_token_valid", 32'(token_valid), 0);
    release_rst(0);

    // Aligned stream: lock on the 4th token strobe
    for (int k = 0; k < 6; k++) begin
      send_sym(T00, 10'(k + 'h100), 10'(k + 'h200));
      if (sym_idx == 5) chk("t1_not_locked_3rd", 32'(snap_locked), 0);
    end
    chk("t1_first_strobe_cyc", 32'(first_cyc), 6);
    chk("t1_second_strobe_cyc", 32'(second_cyc), 11);
    chk("t1_locked", 32'(snap_locked), 1);
    chk("t1_offset", 32'(snap_off), 0);
    chk("t1_ctrl", 32'(snap_ctrl), 0);
    chk("t1_token_valid", 32'(snap_tok), 1);
    chk_words("t1_word");

    // Token 11 with fixed patterns on the data channels
    send_sym(T11, 10'h2AA, 10'h155);
    send_sym(T00, 10'h111, 10'h222);
    send_sym(T00, 10'h333, 10'h044);
    chk("t6_token_valid", 32'(snap_tok), 1);
    chk("t6_ctrl", 32'(snap_ctrl), 3);
    chk("t6_ch0", 32'(snap_data[0]), 32'(T11));
    chk("t6_ch1", 32'(snap_data[1]), 32'h2AA);
    chk("t6_ch2", 32'(snap_data[2]), 32'h155);
    chk("t6_locked", 32'(snap_locked), 1);

    // One-clock reset while locked
    reset_assert(1);
    chk("t5_data", 32'(tmds_internal), 0);
    chk("t5_word_valid", 32'(word_valid), 0);
    chk("t5_locked", 32'(locked), 0);
    chk("t5_token_valid", 32'(token_valid), 0);
    chk("t5_ctrl", 32'(ctrl), 0);
    release_rst(0);

    // Token run broken by a data symbol in CONFIRM
    for (int k = 0; k < 10; k++) begin
      send_sym(t3_seq[k], 10'(k), 10'(k + 100));
      if (sym_idx == 3) begin
        chk("t5_first_strobe_cyc", 32'(first_cyc), 6);
        chk("t5_second_strobe_cyc", 32'(second_cyc), 11);
      end
      if (sym_idx == 5) begin
        chk("t3_ctrl_01", 32'(snap_ctrl), 1);
        chk("t3_locked_before_data", 32'(snap_locked), 0);
      end
      if (sym_idx == 6) begin
        chk("t3_data_word", 32'(snap_data[0]), 32'(DAT));
        chk("t3_data_not_token", 32'(snap_tok), 0);
        chk("t3_ctrl_held", 32'(snap_ctrl), 1);
        chk("t3_offset_kept", 32'(snap_off), 0);
      end
      if (sym_idx == 7) chk("t3_run_cleared", 32'(snap_locked), 0);
      if (sym_idx == 9) chk("t3_not_locked_3rd", 32'(snap_locked), 0);
    end
    chk("t3_relocked", 32'(snap_locked), 1);
    chk("t3_relock_offset", 32'(snap_off), 0);

    // 7-bit delayed stream: slip 0..7, then lock and carry data
    reset_assert(3);
    release_rst(7);
    for (int k = 0; k < 117; k++) begin
      send_sym(T00, 10'(k * 7), 10'(k * 13 + 1));
      if (sym_idx == 16) chk("t2_off_before_slip", 32'(snap_off), 0);
      if (sym_idx == 17) chk("t2_off_first_slip", 32'(snap_off), 1);
      if (sym_idx == 113) begin
        chk("t2_off_reached_7", 32'(snap_off), 7);
        chk("t2_unlocked_at_7", 32'(snap_locked), 0);
      end
      if (sym_idx == 116) chk("t2_not_locked_3rd", 32'(snap_locked), 0);
    end
    chk("t2_locked", 32'(snap_locked), 1);
    chk("t2_offset", 32'(snap_off), 7);
    for (int k = 0; k < 6; k++) begin
      send_sym(d_seq[k], ~d_seq[k], d_seq[k] ^ 10'h155);
      chk_words("t2_data");
    end
    chk("t2_still_locked", 32'(snap_locked), 1);
    chk("t2_strobe_count", n_strobe, sym_idx - 1);

    // 9-bit delayed stream: lock at 9, then lose lock after the idle window
    reset_assert(2);
    release_rst(9);
    for (int k = 0; k < 149; k++) begin
      send_sym(T00, 10'h0AA, 10'h3F0);
      if (sym_idx == 148) chk("t4_not_locked_3rd", 32'(snap_locked), 0);
    end
    chk("t4_locked", 32'(snap_locked), 1);
    chk("t4_offset_9", 32'(snap_off), 9);
    for (int k = 0; k < 34; k++) begin
      send_sym(DAT, 10'h0AA, 10'h3F0);
      if (sym_idx == 182) begin
        chk("t4_locked_before_window", 32'(snap_locked), 1);
        chk("t4_offset_before_window", 32'(snap_off), 9);
      end
    end
    chk("t4_unlocked", 32'(snap_locked), 0);
    chk("t4_offset_wrapped", 32'(snap_off), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
